axis_iter_divider: RTL and testbench

//  32-bit iterative divider with AXI-stream-style inputs and output. It is the multi-cycle

---
 rtl/div_pkg.sv | 11 +
 rtl/axis_iter_divider.sv | 109 ++++++++++
 tb/tb_axis_iter_divider.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative 32-bit divider.
package div_pkg;
  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = 34;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction
endpackage

// File: rtl/axis_iter_divider.sv
// Restoring radix-2 divider, one quotient bit per cycle, AXI-stream style handshake
// without backpressure. Result word is {quotient, remainder}.
module axis_iter_divider
  import div_pkg::*;
#(
  parameter bit SIGNED = 1'b1,
  parameter int WIDTH  = DIV_WIDTH
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               s_axis_divisor_tvalid,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_dividend_tvalid,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  state_t             r_state, w_next;
  logic [4:0]         r_cnt;
  logic               r_fix_ph;
  logic               r_a_neg, r_q_neg;
  logic [WIDTH-1:0]   r_b, r_q, r_rem;
  logic [2*WIDTH-1:0] r_tdata;

  logic               w_accept;
  logic signed [WIDTH-1:0] w_a_s, w_b_s;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_shift, w_sub;

  assign w_accept = (r_state == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
  assign w_a_s    = s_axis_dividend_tdata;
  assign w_b_s    = s_axis_divisor_tdata;
  assign w_a_neg  = SIGNED && (w_a_s < 0);
  assign w_b_neg  = SIGNED && (w_b_s < 0);
  // abs(-2^31) wraps to 32'h80000000, which is the correct unsigned magnitude
  assign w_a_mag  = w_a_neg ? neg32(s_axis_dividend_tdata) : s_axis_dividend_tdata;
  assign w_b_mag  = w_b_neg ? neg32(s_axis_divisor_tdata) : s_axis_divisor_tdata;

  // Partial remainder stays below the divisor, so bit WIDTH of the 33-bit difference
  // is exactly the borrow; a zero divisor never borrows and yields all-ones, R = A.
  assign w_shift  = {r_rem, r_q[WIDTH-1]};
  assign w_sub    = w_shift - {1'b0, r_b};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (r_cnt == 5'd31) w_next = FIX;
      FIX:     if (r_fix_ph) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Control: iteration count, fix phase and the held result word
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cnt    <= 5'd0;
      r_fix_ph <= 1'b0;
      r_tdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_cnt    <= 5'd0;
          r_fix_ph <= 1'b0;
        end
        CALC: r_cnt <= r_cnt + 5'd1;
        FIX: begin
          r_fix_ph <= 1'b1;
          if (r_fix_ph) r_tdata <= {r_q, r_rem};
        end
        default: ;
      endcase
    end
  end

  // Datapath: operand latch, restoring step, then sign application in FIX phase 0
  always_ff @(posedge aclk) begin
    case (r_state)
      IDLE: if (w_accept) begin
        r_b     <= w_b_mag;
        r_q     <= w_a_mag;
        r_rem   <= '0;
        r_a_neg <= w_a_neg;
        r_q_neg <= w_a_neg ^ w_b_neg;
      end
      CALC: begin
        r_q   <= {r_q[WIDTH-2:0], ~w_sub[WIDTH]};
        r_rem <= w_sub[WIDTH] ? w_shift[WIDTH-1:0] : w_sub[WIDTH-1:0];
      end
      FIX: if (!r_fix_ph) begin
        r_q   <= r_q_neg ? neg32(r_q) : r_q;
        r_rem <= r_a_neg ? neg32(r_rem) : r_rem;
      end
      default: ;
    endcase
  end

  assign m_axis_dout_tvalid = (r_state == DONE);
  assign m_axis_dout_tdata  = r_tdata;

endmodule

// File: tb/tb_axis_iter_divider.sv
// Directed bench driving a signed and an unsigned divider with the same operands.
module tb_axis_iter_divider;
  logic        aclk = 1'b0;
  logic        areset;
  logic        div_vld, dvd_vld;
  logic [31:0] div_data, dvd_data;
  logic        vld_s, vld_u;
  logic [63:0] dout_s, dout_u;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 aclk = ~aclk;

  axis_iter_divider #(.SIGNED(1'b1), .WIDTH(32)) u_div_s (
    .aclk(aclk), .areset(areset),
    .s_axis_divisor_tvalid(div_vld), .s_axis_divisor_tdata(div_data),
    .s_axis_dividend_tvalid(dvd_vld), .s_axis_dividend_tdata(dvd_data),
    .m_axis_dout_tvalid(vld_s), .m_axis_dout_tdata(dout_s)
  );

  axis_iter_divider #(.SIGNED(1'b0), .WIDTH(32)) u_div_u (
    .aclk(aclk), .areset(areset),
    .s_axis_divisor_tvalid(div_vld), .s_axis_divisor_tdata(div_data),
    .s_axis_dividend_tvalid(dvd_vld), .s_axis_dividend_tdata(dvd_data),
    .m_axis_dout_tvalid(vld_u), .m_axis_dout_tdata(dout_u)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_pair(input logic [31:0] a, input logic [31:0] b);
    dvd_data = a;
    div_data = b;
    dvd_vld  = 1'b1;
    div_vld  = 1'b1;
    @(posedge aclk);
    #1;
    dvd_vld  = 1'b0;
    div_vld  = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_s, input logic [63:0] exp_u);
    int lat;
    lat = -1;
    drive_pair(a, b);
    for (int i = 1; i <= 40; i++) begin
      @(posedge aclk);
      #1;
      if (vld_s) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'd34);
    check({tag, " u_vld"}, 64'(vld_u), 64'd1);
    check({tag, " signed"}, dout_s, exp_s);
    check({tag, " unsigned"}, dout_u, exp_u);
    @(posedge aclk);
    #1;
    check({tag, " pulse"}, 64'(vld_s | vld_u), 64'd0);
  endtask

  initial begin
    int pulses, first;
    areset   = 1'b1;
    div_vld  = 1'b0;
    dvd_vld  = 1'b0;
    div_data = '0;
    dvd_data = '0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    check("reset vld", 64'({vld_s, vld_u}), 64'd0);
    check("reset dout_s", dout_s, 64'd0);
    check("reset dout_u", dout_u, 64'd0);

    do_op("100/7", 32'd100, 32'd7, {32'd14, 32'd2}, {32'd14, 32'd2});
    do_op("-7/2", 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, {32'h7FFF_FFFC, 32'd1});
    do_op("7/-2", 32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'd1}, {32'd0, 32'd7});
    do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, {32'd0, 32'h8000_0000});
    do_op("5/0", 32'd5, 32'd0, {32'hFFFF_FFFF, 32'd5}, {32'hFFFF_FFFF, 32'd5});
    do_op("-5/0", 32'hFFFF_FFFB, 32'd0, {32'd1, 32'hFFFF_FFFB}, {32'hFFFF_FFFF, 32'hFFFF_FFFB});

    // New valid pair while busy must be dropped
    pulses = 0;
    first  = -1;
    drive_pair(32'd100, 32'd7);
    for (int i = 1; i <= 80; i++) begin
      if (i == 10) begin
        dvd_data = 32'd1000; div_data = 32'd3; dvd_vld = 1'b1; div_vld = 1'b1;
      end
      if (i == 11) begin
        dvd_vld = 1'b0; div_vld = 1'b0;
      end
      @(posedge aclk);
      #1;
      if (vld_s) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check("busy pulses", 64'(pulses), 64'd1);
    check("busy latency", 64'(first), 64'd34);
    check("busy dout", dout_s, {32'd14, 32'd2});

    // Divisor valid alone starts nothing
    pulses = 0;
    dvd_data = 32'd9; div_data = 32'd3; div_vld = 1'b1;
    @(posedge aclk);
    #1;
    div_vld = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge aclk);
      #1;
      if (vld_s || vld_u) pulses++;
    end
    check("one valid", 64'(pulses), 64'd0);

    // Reset mid-operation aborts without a result pulse
    pulses = 0;
    drive_pair(32'd200, 32'd3);
    for (int i = 1; i <= 60; i++) begin
      if (i == 20) areset = 1'b1;
      if (i == 21) areset = 1'b0;
      @(posedge aclk);
      #1;
      if (vld_s || vld_u) pulses++;
    end
    check("abort pulses", 64'(pulses), 64'd0);
    check("abort dout_s", dout_s, 64'd0);
    check("abort dout_u", dout_u, 64'd0);
    do_op("200/3", 32'd200, 32'd3, {32'd66, 32'd2}, {32'd66, 32'd2});

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
